// File: rtl/dac_wave_gen_pkg.sv
// Shared types and constants for the DAC waveform generator.
// Latency: n/a (types only).
// Backpressure: n/a.
//
// Contents: waveform selector enum, generator FSM state enum,
// sample width and dither LFSR seed.
package dac_pkg;

  localparam int          DAC_W     = 16;
  localparam logic [15:0] LFSR_SEED = 16'hACE1;

  typedef enum logic [1:0] {
    WAVE_SAW     = 2'd0,
    WAVE_TRI     = 2'd1,
    WAVE_SQUARE  = 2'd2,
    WAVE_RAMP_DN = 2'd3
  } wave_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CALC  = 2'd1,
    SCALE = 2'd2,
    HOLD  = 2'd3
  } wg_state_e;

endpackage

// File: rtl/dac_wave_gen_if.sv
// AXI-stream sample channel between the waveform generator and the DAC driver.
// Latency: n/a (wires only).
// Backpressure: master holds valid/data until ready is seen with valid high.
//
// Signals: m_axis_valid (sample available), m_axis_ready (sample accepted),
// m_axis_data (16-bit straight-binary sample).
interface dac_wave_gen_if import dac_pkg::*; ();

  logic             m_axis_valid;
  logic             m_axis_ready;
  logic [DAC_W-1:0] m_axis_data;

  modport master (
    output m_axis_valid,
    output m_axis_data,
    input  m_axis_ready
  );

  modport slave (
    input  m_axis_valid,
    input  m_axis_data,
    output m_axis_ready
  );

endinterface

// File: rtl/dac_wave_gen_shaper.sv
// Maps a 16-bit phase index to a raw unipolar waveform sample.
// Latency: combinational; registered by the caller.
// Backpressure: none.
//
// Ports: i_wave_sel (waveform choice), i_idx (phase index), o_raw (raw sample).
module wave_shaper
  import dac_pkg::*;
(
  input  wave_e            i_wave_sel,
  input  logic [DAC_W-1:0] i_idx,
  output logic [DAC_W-1:0] o_raw
);

  always_comb begin
    o_raw = '0;
    case (i_wave_sel)
      WAVE_SAW:     o_raw = i_idx;
      WAVE_RAMP_DN: o_raw = ~i_idx;
      WAVE_SQUARE:  o_raw = i_idx[15] ? 16'h0000 : 16'hFFFF;
      // Fold the top half back down so the peak lands at idx 0x8000.
      WAVE_TRI:     o_raw = i_idx[15] ? {~i_idx[14:0], 1'b0} : {i_idx[14:0], 1'b0};
      default:      o_raw = '0;
    endcase
  end

endmodule

// File: rtl/dac_wave_gen.sv
// Phase-accumulator waveform source feeding the AD5541A DAC driver over AXI-stream.
// Latency: en->valid 3 cycles; handshake->next valid 2 cycles.
// Backpressure: each sample is held (valid high, data stable) until accepted.
//
// Ports: mclk/rst (clock, async active-high reset), en, freq_word, wave_sel,
// amplitude, offset (config), m_axis (master side of dac_wave_gen_if).
// Optional: define WAVE_GEN_DITHER_EN to add 2-bit LFSR dither after saturation.
module dac_wave_gen
  import dac_pkg::*;
#(
  parameter int PHASE_W = 32
) (
  input  logic               mclk,
  input  logic               rst,
  input  logic               en,
  input  logic [PHASE_W-1:0] freq_word,
  input  logic [1:0]         wave_sel,
  input  logic [DAC_W-1:0]   amplitude,
  input  logic [DAC_W-1:0]   offset,
  dac_wave_gen_if.master     m_axis
);

  wg_state_e          r_state;
  logic [PHASE_W-1:0] r_phase;
  logic [DAC_W-1:0]   r_amp;
  logic [DAC_W-1:0]   r_off;
  logic [DAC_W-1:0]   r_raw;
  logic               r_valid;
  logic [DAC_W-1:0]   r_data;

  logic [DAC_W-1:0]   w_idx;
  logic [DAC_W-1:0]   w_raw;
  logic [32:0]        w_prod;
  logic [DAC_W-1:0]   w_scaled;
  logic [DAC_W:0]     w_sum;
  logic [DAC_W-1:0]   w_sat;
  logic [DAC_W-1:0]   w_out;
  logic               w_unused_prod;

  assign w_idx = r_phase[PHASE_W-1 -: DAC_W];

  wave_shaper u_shaper (
    .i_wave_sel (wave_e'(wave_sel)),
    .i_idx      (w_idx),
    .o_raw      (w_raw)
  );

  // raw*(amplitude+1): full-scale amplitude passes raw through unchanged.
  assign w_prod        = 33'(r_raw) * 33'(r_amp) + 33'(r_raw);
  assign w_scaled      = w_prod[31:16];
  assign w_unused_prod = ^{w_prod[32], w_prod[15:0]};
  assign w_sum         = {1'b0, w_scaled} + {1'b0, r_off};
  assign w_sat         = w_sum[DAC_W] ? 16'hFFFF : w_sum[DAC_W-1:0];

`ifdef WAVE_GEN_DITHER_EN
  logic [DAC_W-1:0] r_lfsr;
  logic [DAC_W:0]   w_dith;

  assign w_dith = {1'b0, w_sat} + {15'b0, r_lfsr[1:0]};
  assign w_out  = w_dith[DAC_W] ? 16'hFFFF : w_dith[DAC_W-1:0];

  // Galois form of x^16+x^14+x^13+x^11+1, stepped once per accepted sample.
  always_ff @(posedge mclk or posedge rst) begin
    if (rst) begin
      r_lfsr <= LFSR_SEED;
    end else if (r_state == HOLD && m_axis.m_axis_ready) begin
      r_lfsr <= {1'b0, r_lfsr[15:1]} ^ (r_lfsr[0] ? 16'hB400 : 16'h0000);
    end
  end
`else
  assign w_out = w_sat;
`endif

  always_ff @(posedge mclk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_phase <= '0;
      r_amp   <= '0;
      r_off   <= '0;
      r_raw   <= '0;
      r_valid <= 1'b0;
      r_data  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (en) r_state <= CALC;
        end
        CALC: begin
          r_amp   <= amplitude;
          r_off   <= offset;
          r_raw   <= w_raw;
          r_state <= SCALE;
        end
        SCALE: begin
          r_data  <= w_out;
          r_valid <= 1'b1;
          r_state <= HOLD;
        end
        HOLD: begin
          // valid is always high here, so ready alone marks the handshake.
          if (m_axis.m_axis_ready) begin
            r_phase <= r_phase + freq_word;
            r_valid <= 1'b0;
            r_state <= en ? CALC : IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign m_axis.m_axis_valid = r_valid;
  assign m_axis.m_axis_data  = r_data;

endmodule
